// File: rtl/gcm_seq_if.sv
// gcm_seq_if: job, block stream, core and result signals of gcm_seq_ctrl
interface gcm_seq_if #(parameter int CNT_W = 8);
  logic             i_job_valid;
  logic             o_job_ready;
  logic [CNT_W-1:0] i_aad_blocks;
  logic [CNT_W-1:0] i_pt_blocks;
  logic             i_blk_valid;
  logic             o_blk_ready;
  logic [127:0]     i_blk_data;
  logic             o_gcm_new_instance;
  logic             o_gcm_pt_instance;
  logic [127:0]     o_gcm_aad;
  logic [127:0]     o_gcm_plain_text;
  logic [63:0]      o_aad_size;
  logic [63:0]      o_pt_size;
  logic             i_gcm_tag_ready;
  logic [127:0]     i_gcm_tag;
  logic             o_tag_valid;
  logic             i_tag_ready;
  logic [127:0]     o_tag;
  logic             o_busy;
  logic             o_timeout;
  modport slave (
    input  i_job_valid, i_aad_blocks, i_pt_blocks, i_blk_valid, i_blk_data,
           i_gcm_tag_ready, i_gcm_tag, i_tag_ready,
    output o_job_ready, o_blk_ready, o_gcm_new_instance, o_gcm_pt_instance,
           o_gcm_aad, o_gcm_plain_text, o_aad_size, o_pt_size, o_tag_valid,
           o_tag, o_busy, o_timeout
  );
  modport master (
    output i_job_valid, i_aad_blocks, i_pt_blocks, i_blk_valid, i_blk_data,
           i_gcm_tag_ready, i_gcm_tag, i_tag_ready,
    input  o_job_ready, o_blk_ready, o_gcm_new_instance, o_gcm_pt_instance,
           o_gcm_aad, o_gcm_plain_text, o_aad_size, o_pt_size, o_tag_valid,
           o_tag, o_busy, o_timeout
  );
endinterface

// File: rtl/gcm_seq_ctrl.sv
// gcm_seq_ctrl: sequences AAD/PT blocks of a job into a GCM core and returns its tag.
// Macro GCM_SEQ_TIMEOUT_EN adds a WAIT_TAG timeout of TAG_TIMEOUT cycles.
module gcm_seq_ctrl #(
  parameter int CNT_W       = 8,
  parameter int TAG_TIMEOUT = 64
) (
  input logic      clk,
  input logic      rst,
  gcm_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, AAD, PT, WAIT_TAG, TAG_OUT} state_t;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_aad_cnt, r_pt_cnt;
  logic             r_first, r_new, r_pt_inst;
  logic [127:0]     r_aad, r_pt, r_tag;
  logic [63:0]      r_aad_size, r_pt_size;
  logic             w_accept, w_xfer, w_expire;
  assign w_accept = bus.i_job_valid & bus.o_job_ready;
  assign w_xfer   = bus.i_blk_valid & bus.o_blk_ready;
`ifdef GCM_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TAG_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TAG_TIMEOUT - 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_timeout;
  assign w_expire = r_state == WAIT_TAG && !bus.i_gcm_tag_ready && r_to_cnt == TO_LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_to_cnt  <= (r_state == WAIT_TAG && !bus.i_gcm_tag_ready && !w_expire) ? r_to_cnt + 1'b1 : '0;
      r_timeout <= w_expire;
    end
  assign bus.o_timeout = r_timeout;
`else
  assign w_expire      = 1'b0;
  assign bus.o_timeout = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_next = |bus.i_aad_blocks ? AAD : |bus.i_pt_blocks ? PT : WAIT_TAG;
      AAD:      if (w_xfer && r_aad_cnt == CNT_W'(1)) w_next = |r_pt_cnt ? PT : WAIT_TAG;
      PT:       if (w_xfer && r_pt_cnt == CNT_W'(1)) w_next = WAIT_TAG;
      WAIT_TAG: w_next = bus.i_gcm_tag_ready ? TAG_OUT : w_expire ? IDLE : WAIT_TAG;
      TAG_OUT:  if (bus.i_tag_ready) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end
  always_comb begin
    bus.o_job_ready = r_state == IDLE;
    bus.o_blk_ready = r_state == AAD || r_state == PT;
    bus.o_tag_valid = r_state == TAG_OUT;
    bus.o_busy      = r_state != IDLE;
  end
  // r_first marks that the next transferred block is the job's first, which carries new_instance
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_aad_cnt  <= '0;
      r_pt_cnt   <= '0;
      r_first    <= 1'b0;
      r_new      <= 1'b0;
      r_pt_inst  <= 1'b0;
      r_aad      <= '0;
      r_pt       <= '0;
      r_tag      <= '0;
      r_aad_size <= '0;
      r_pt_size  <= '0;
    end else begin
      r_new     <= 1'b0;
      r_pt_inst <= 1'b0;
      if (w_accept) begin
        r_aad_cnt  <= bus.i_aad_blocks;
        r_pt_cnt   <= bus.i_pt_blocks;
        r_aad_size <= 64'({bus.i_aad_blocks, 7'd0});
        r_pt_size  <= 64'({bus.i_pt_blocks, 7'd0});
        r_first    <= |bus.i_aad_blocks | |bus.i_pt_blocks;
        r_new      <= ~|bus.i_aad_blocks & ~|bus.i_pt_blocks;
      end
      if (w_xfer) begin
        r_first <= 1'b0;
        r_new   <= r_first;
        if (r_state == AAD) begin
          r_aad     <= bus.i_blk_data;
          r_aad_cnt <= r_aad_cnt - 1'b1;
        end else begin
          r_pt      <= bus.i_blk_data;
          r_pt_inst <= 1'b1;
          r_pt_cnt  <= r_pt_cnt - 1'b1;
        end
      end
      if (r_state == WAIT_TAG && bus.i_gcm_tag_ready) r_tag <= bus.i_gcm_tag;
    end
  assign bus.o_gcm_new_instance = r_new;
  assign bus.o_gcm_pt_instance  = r_pt_inst;
  assign bus.o_gcm_aad          = r_aad;
  assign bus.o_gcm_plain_text   = r_pt;
  assign bus.o_aad_size         = r_aad_size;
  assign bus.o_pt_size          = r_pt_size;
  assign bus.o_tag              = r_tag;
endmodule

// File: tb/tb_gcm_seq_ctrl.sv
// tb_gcm_seq_ctrl: directed jobs with a scoreboard of PT blocks and tags
module tb_gcm_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  gcm_seq_if #(.CNT_W(8)) bus();
  gcm_seq_ctrl #(.CNT_W(8), .TAG_TIMEOUT(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0, fails = 0, n_new = 0, n_pt = 0;
  logic [127:0] q_pt[$], q_tag[$];
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (rst === 1'b0) begin
    if (bus.o_gcm_new_instance === 1'b1) n_new++;
    if (bus.o_gcm_pt_instance === 1'b1) begin
      n_pt++;
      if (q_pt.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL pt_unexpected: got %h expected none", bus.o_gcm_plain_text);
      end else chk("pt_data", bus.o_gcm_plain_text, q_pt.pop_front());
    end
    if (bus.o_tag_valid === 1'b1 && bus.i_tag_ready === 1'b1) begin
      if (q_tag.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL tag_unexpected: got %h expected none", bus.o_tag);
      end else chk("tag_out", bus.o_tag, q_tag.pop_front());
    end
  end
  task automatic send(input logic [127:0] d, input bit is_pt, input bit first_exp, input int gap);
    int w;
    w = 0;
    if (is_pt) q_pt.push_back(d);
    bus.i_blk_data  = d;
    bus.i_blk_valid = 1'b1;
    while (bus.o_blk_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("blk_ready_wait", 128'(w < 50), 128'(1));
    @(posedge clk);
    #1 bus.i_blk_valid = 1'b0;
    @(negedge clk);
    if (is_pt) chk("pt_pulse", 128'(bus.o_gcm_pt_instance), 128'(1));
    else chk("aad_data", bus.o_gcm_aad, d);
    chk("new_inst", 128'(bus.o_gcm_new_instance), 128'(first_exp));
    repeat (gap) begin
      @(negedge clk);
      chk("stall_quiet", 128'({bus.o_gcm_new_instance, bus.o_gcm_pt_instance}), 128'(0));
    end
  endtask
  task automatic finish_tag(input logic [127:0] tag);
    chk("wait_state", 128'({bus.o_busy, bus.o_tag_valid}), 128'(2'b10));
    bus.i_gcm_tag       = tag;
    bus.i_gcm_tag_ready = 1'b1;
    q_tag.push_back(tag);
    @(posedge clk);
    #1 bus.i_gcm_tag_ready = 1'b0;
    bus.i_gcm_tag = ~tag;
    @(negedge clk);
    chk("tag_valid", 128'(bus.o_tag_valid), 128'(1));
    chk("tag_capture", bus.o_tag, tag);
    repeat (2) @(negedge clk);
    chk("tag_hold", {bus.o_tag[126:0], bus.o_tag_valid}, {tag[126:0], 1'b1});
    @(posedge clk);
    #1 bus.i_tag_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_tag_ready = 1'b0;
    @(negedge clk);
    chk("back_idle", 128'({bus.o_job_ready, bus.o_busy, bus.o_tag_valid}), 128'(3'b100));
  endtask
  task automatic run_job(input int na, input int np, input int gap, input logic [127:0] aad0,
                         input logic [127:0] pt0, input logic [127:0] tag, input bit fin);
    int n0, p0;
    logic [127:0] d;
    n0 = n_new;
    p0 = n_pt;
    chk("job_ready", 128'(bus.o_job_ready), 128'(1));
    bus.i_aad_blocks = 8'(na);
    bus.i_pt_blocks  = 8'(np);
    bus.i_job_valid  = 1'b1;
    @(posedge clk);
    #1 bus.i_job_valid = 1'b0;
    @(negedge clk);
    chk("aad_size", 128'(bus.o_aad_size), 128'(na * 128));
    chk("pt_size", 128'(bus.o_pt_size), 128'(np * 128));
    if (na == 0 && np == 0) chk("new_inst_00", 128'(bus.o_gcm_new_instance), 128'(1));
    for (int i = 0; i < na; i++) begin
      d = (i == 0) ? aad0 : {$urandom, $urandom, $urandom, $urandom};
      send(d, 1'b0, i == 0, gap);
    end
    for (int i = 0; i < np; i++) begin
      d = (i == 0) ? pt0 : {$urandom, $urandom, $urandom, $urandom};
      send(d, 1'b1, na == 0 && i == 0, gap);
    end
    if (fin) begin
      finish_tag(tag);
      chk("new_count", 128'(n_new - n0), 128'(1));
      chk("pt_count", 128'(n_pt - p0), 128'(np));
    end
  endtask
  initial begin
    int n;
    logic tv;
    rst = 1'b1;
    bus.i_job_valid = 0; bus.i_aad_blocks = 0; bus.i_pt_blocks = 0;
    bus.i_blk_valid = 0; bus.i_blk_data = 0;
    bus.i_gcm_tag_ready = 0; bus.i_gcm_tag = 0; bus.i_tag_ready = 0;
    #12;
    chk("rst_ready", 128'({bus.o_job_ready, bus.o_blk_ready, bus.o_busy, bus.o_tag_valid, bus.o_timeout}), 128'(5'b10000));
    chk("rst_data", bus.o_gcm_aad | bus.o_gcm_plain_text | bus.o_tag | 128'(bus.o_aad_size | bus.o_pt_size), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    run_job(1, 1, 0, 128'h3AD77BB40D7A3660A89ECAF32466EF97, 128'hD9313225F88406E5A55909C5AFF5269A,
            128'h58E2FCCEFA7E3061367F1D57A4E7455A, 1'b1);
    run_job(4, 4, 1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            128'h0123456789ABCDEF0011223344556677, 1'b1);
    bus.i_aad_blocks = 0;
    bus.i_pt_blocks  = 3;
    bus.i_job_valid  = 1'b1;
    @(posedge clk);
    #1 bus.i_job_valid = 1'b0;
    @(negedge clk);
    send(128'hCAFEF00D_00000000_11111111_22222222, 1'b1, 1'b1, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ctrl", 128'({bus.o_job_ready, bus.o_blk_ready, bus.o_busy, bus.o_tag_valid, bus.o_gcm_pt_instance, bus.o_gcm_new_instance}), 128'(6'b100000));
    chk("midrst_data", bus.o_gcm_plain_text | 128'(bus.o_pt_size), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    run_job(0, 2, 0, 128'h0, {$urandom, $urandom, $urandom, $urandom}, 128'hFEEDFACE_DEADBEEF_01020304_A5A5A5A5, 1'b1);
    run_job(0, 0, 0, 128'h0, 128'h0, 128'h0, 1'b0);
`ifdef GCM_SEQ_TIMEOUT_EN
    n = 0;
    tv = 1'b0;
    while (bus.o_timeout !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      tv = tv | bus.o_tag_valid;
    end
    chk("timeout_cycles", 128'(n), 128'(64));
    chk("timeout_no_tag", 128'(tv), 128'(0));
    @(negedge clk);
    chk("timeout_pulse", 128'({bus.o_timeout, bus.o_job_ready}), 128'(2'b01));
`else
    n = 0;
    tv = 1'b0;
    repeat (100) begin
      @(negedge clk);
      n++;
      tv = tv | bus.o_timeout | bus.o_tag_valid;
    end
    chk("no_timeout", 128'({tv, bus.o_busy}), 128'(2'b01));
    finish_tag(128'h00000000_11111111_22222222_33333333);
`endif
    chk("sb_empty", 128'(q_pt.size() + q_tag.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gcm_seq_ctrl.md
GCM_SEQ_CTRL -- requirements
Module: gcm_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, block-count width per job.
REQ-002 SHALL have parameter TAG_TIMEOUT, default 64, maximum cycles spent in WAIT_TAG.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have job ports: i_job_valid in 1, o_job_ready out 1, i_aad_blocks in CNT_W, i_pt_blocks in CNT_W.
REQ-006 SHALL have block stream ports: i_blk_valid in 1, o_blk_ready out 1, i_blk_data in 128 (AAD blocks first, then PT blocks).
REQ-007 SHALL have core drive ports: o_gcm_new_instance out 1, o_gcm_pt_instance out 1, o_gcm_aad out 128, o_gcm_plain_text out 128, o_aad_size out 64, o_pt_size out 64.
REQ-008 SHALL have core return ports: i_gcm_tag_ready in 1, i_gcm_tag in 128.
REQ-009 SHALL have result ports: o_tag_valid out 1, i_tag_ready in 1, o_tag out 128, o_busy out 1, o_timeout out 1.

Function
REQ-010 SHALL implement states IDLE, AAD, PT, WAIT_TAG, TAG_OUT.
REQ-011 SHALL assert o_job_ready only in IDLE; a job is accepted on a cycle with i_job_valid & o_job_ready.
REQ-012 SHALL on acceptance latch counts, set o_aad_size = i_aad_blocks*128 and o_pt_size = i_pt_blocks*128 zero-extended to 64 bits, held until next acceptance.
REQ-013 SHALL go from IDLE to AAD if aad count > 0, else PT if pt count > 0, else WAIT_TAG.
REQ-014 SHALL assert o_blk_ready only in AAD and PT; a block transfers on i_blk_valid & o_blk_ready.
REQ-015 SHALL register each transferred block to o_gcm_aad (in AAD) or o_gcm_plain_text (in PT) one cycle after transfer, holding the value otherwise.
REQ-016 SHALL pulse o_gcm_new_instance for exactly one cycle, coincident with the first block presented to the core for the job (AAD or PT); for a 0/0 job, one cycle after acceptance.
REQ-017 SHALL pulse o_gcm_pt_instance for exactly one cycle with each PT block presented to the core.
REQ-018 SHALL decrement the active count per transfer; last AAD -> PT (or WAIT_TAG if pt count 0); last PT -> WAIT_TAG.
REQ-019 SHALL, with i_blk_valid low, stall in AAD/PT with no pulses and no count change.
REQ-020 SHALL in WAIT_TAG capture i_gcm_tag into o_tag on the first cycle i_gcm_tag_ready is high and move to TAG_OUT.
REQ-021 SHALL ignore i_gcm_tag_ready outside WAIT_TAG.
REQ-022 SHALL hold o_tag_valid high in TAG_OUT with o_tag stable until i_tag_ready, then return to IDLE.
REQ-023 SHALL drive o_busy high in every state except IDLE.

Reset
REQ-024 SHALL on rst, immediately and regardless of clk, enter IDLE, clear counts and the timeout counter, and drive every output to 0 except o_job_ready = 1.
REQ-025 SHALL abandon any in-flight job on rst mid-operation without emitting a tag; the first job after rst deasserts starts with a fresh o_gcm_new_instance pulse.

Configuration
REQ-026 SHALL, with macro GCM_SEQ_TIMEOUT_EN defined, count WAIT_TAG cycles, and after TAG_TIMEOUT cycles without i_gcm_tag_ready, pulse o_timeout for one cycle and return to IDLE without o_tag_valid.
REQ-027 SHALL, without GCM_SEQ_TIMEOUT_EN, omit the counter, tie o_timeout to 0 and wait in WAIT_TAG indefinitely.

Verification
REQ-028 SHALL cover key 0, iv 0, aad 1 block 3AD77BB40D7A3660A89ECAF32466EF97, pt 1 block D9313225F88406E5A55909C5AFF5269A -> one new_instance pulse with the AAD block, one pt_instance pulse, sizes 128/128, tag equals the core tag, o_tag_valid held until i_tag_ready.
REQ-029 SHALL cover aad=4, pt=4 with i_blk_valid toggling every other cycle -> exactly 4 AAD and 4 pt_instance pulses in order, no pulse during stalls, sizes 512/512.
REQ-030 SHALL cover aad=0, pt=2 -> new_instance coincident with first pt_instance pulse, o_aad_size 0, o_pt_size 256.
REQ-031 SHALL cover rst asserted mid-PT after 1 of 3 blocks -> outputs cleared same cycle, o_job_ready 1, no tag; next job runs normally.
REQ-032 SHALL cover, with GCM_SEQ_TIMEOUT_EN defined and TAG_TIMEOUT=64, i_gcm_tag_ready held low -> o_timeout pulses once after 64 WAIT_TAG cycles, state returns to IDLE, o_tag_valid never asserted.
